vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing and test-pattern generator. It is the configurable successor to the fixed 640x480@60 Hz generator. Runs in the pixel clock domain and drives the DVI/TMDS encoder path with colour, hsync, vsync and blank. Adds per-mode porch/sync widths, selectable sync polarity, clock enable, pixel coordinate outputs, frame/line strobes and four frame-synchronous test patterns.

## Interface
- H_VISIBLE, 640, visible pixels per line; must be a multiple of 8
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch in lines
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level
- COLOR_BITS, 3, bits per colour channel
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- enable  in  1  pixel clock enable; low = freeze everything
- mode  in  2  pattern select, sampled at frame boundary
- red, green, blue  out  COLOR_BITS each  pixel colour, registered
- hsync, vsync  out  1  sync, registered, polarity per parameter
- blank  out  1  high outside visible area, registered
- x  out  XW  column of current output pixel
- y  out  YW  line of current output pixel
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- line_start  out  1  one-cycle pulse with pixel (0,y), every line including blanked lines

## Operation
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). On an enabled edge, h increments; at H_TOTAL-1 it wraps to 0 and v increments; v wraps at V_TOTAL-1.
- Internal mode_q is loaded from mode only on the enabled edge where h=H_TOTAL-1 and v=V_TOTAL-1. A mode change mid-frame therefore takes effect at the next frame's first pixel.
- Horizontal sync is active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC. Vertical sync is active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
- Output level = active ? *_POL : ~*_POL.
- blank = (h >= H_VISIBLE) || (v >= V_VISIBLE). Colours are 0 whenever blank.
- Visible patterns (ONES = all COLOR_BITS set):
  - mode 0, gradient: red = v[COLOR_BITS+3:4], green = v[COLOR_BITS+2:3], blue = h[COLOR_BITS+3:4].
  - mode 1, colour bars: 8 bars each H_VISIBLE/8 wide. Bar index b comes from a bar counter reset at h=0 and advanced every H_VISIBLE/8 pixels; no divider. red = b[2]?ONES:0, green = b[1]?ONES:0, blue = b[0]?ONES:0. Bar 0 is black, bar 7 is white.
  - mode 2, checkerboard: all channels ONES when h[4]^v[4], else 0.
  - mode 3: solid white (ONES on all channels).
- x, y = the h, v that produced the current outputs.

## Timing
- All outputs are registered: state at counter (h,v) appears at outputs one clk after the counter holds (h,v). Latency is identical for colour, sync, blank, x/y and strobes, so they are mutually aligned.
- Reset (async assert, sync release is the system's job):
  - h=v=0, mode_q=0, bar counter 0
  - colours 0, blank=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - x=y=0, frame_start=line_start=0
- First enabled edge after reset presents pixel (0,0): blank=0, frame_start=1, line_start=1, with mode 0 colours.
- enable low: counters, mode_q and every output register hold their value. Strobes hold too, so a pulse lasts as long as enable stays low. A frame boundary during enable-low does not sample mode.
- Reset asserted mid-frame: immediate return to reset values. The next frame starts at (0,0) with mode_q=0.
- Line period is H_TOTAL enabled cycles; frame period is H_TOTAL*V_TOTAL enabled cycles (420000 at defaults).

## Test plan
- Reset and first pixel: assert reset mid-frame -> all outputs at reset values at once. Release, then 1 enabled edge -> frame_start=1, line_start=1, x=0, y=0, blank=0.
- Horizontal timing at defaults: hsync goes low exactly 656 cycles after the line_start pulse and stays low 96 cycles. blank rises at cycle 640. line_start repeats every 800 cycles.
- Vertical timing at defaults: vsync low for exactly 2 lines (y=490,491). frame_start period is 420000 cycles. blank stays high for y>=480.
- Mode switching: mode=1 applied at y=100 -> gradient persists until frame end. Next frame shows 8 bars of 80 pixels: x=0..79 black, x=560..639 white.
- enable gating and polarity: enable low for 37 cycles mid-line -> outputs frozen, after which the sequence resumes with no skipped pixel. With HSYNC_POL=1, VSYNC_POL=1 the sync pulses are high.
- Small parameters (H 8/2/2/2, V 4/1/1/1, mode 2): check line=14, frame=98 cycles; sync and blank positions; checkerboard is white at (16,0) only when in range.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing and test-pattern generator
module vga_timing_gen #(
  parameter int   H_VISIBLE  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   COLOR_BITS = 3,
  localparam int  H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int  XW         = $clog2(H_TOTAL),
  localparam int  YW         = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic                  frame_start,
  output logic                  line_start
);

  localparam int BAR_W  = H_VISIBLE / 8;
  localparam int HS_BEG = H_VISIBLE + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam logic [COLOR_BITS-1:0] ONES = '1;

  logic [XW-1:0]         h, h_nxt;
  logic [YW-1:0]         v, v_nxt;
  logic [XW-1:0]         bar_cnt, bar_cnt_nxt;
  logic [2:0]            bar, bar_nxt;
  logic [1:0]            mode_q, mode_nxt;
  logic [31:0]           hx, vx;
  logic                  h_last, v_last;
  logic                  blank_d, hs_act, vs_act;
  logic [COLOR_BITS-1:0] r_d, g_d, b_d;

  // Counters widened to 32 bits so pattern bit-selects and porch compares
  // stay legal for small timing parameters.
  assign hx     = 32'(h);
  assign vx     = 32'(v);
  assign h_last = (hx == 32'(H_TOTAL - 1));
  assign v_last = (vx == 32'(V_TOTAL - 1));

  // State register: raster counters, bar tracker and frame-latched mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h       <= '0;
      v       <= '0;
      bar_cnt <= '0;
      bar     <= '0;
      mode_q  <= '0;
    end else begin
      h       <= h_nxt;
      v       <= v_nxt;
      bar_cnt <= bar_cnt_nxt;
      bar     <= bar_nxt;
      mode_q  <= mode_nxt;
    end
  end

  // Next-state: advance raster when enabled; bar index steps every BAR_W pixels
  always_comb begin
    h_nxt       = h;
    v_nxt       = v;
    bar_cnt_nxt = bar_cnt;
    bar_nxt     = bar;
    mode_nxt    = mode_q;
    if (enable) begin
      if (h_last) begin
        h_nxt       = '0;
        bar_cnt_nxt = '0;
        bar_nxt     = '0;
        if (v_last) begin
          v_nxt    = '0;
          mode_nxt = mode;
        end else begin
          v_nxt = v + YW'(1);
        end
      end else begin
        h_nxt = h + XW'(1);
        if (bar_cnt == XW'(BAR_W - 1)) begin
          bar_cnt_nxt = '0;
          bar_nxt     = bar + 3'd1;
        end else begin
          bar_cnt_nxt = bar_cnt + XW'(1);
        end
      end
    end
  end

  // Output decode: sync windows, blanking and the selected test pattern
  always_comb begin
    blank_d = (hx >= 32'(H_VISIBLE)) || (vx >= 32'(V_VISIBLE));
    hs_act  = (hx >= 32'(HS_BEG)) && (hx < 32'(HS_END));
    vs_act  = (vx >= 32'(VS_BEG)) && (vx < 32'(VS_END));
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (!blank_d) begin
      case (mode_q)
        2'd0: begin
          r_d = vx[COLOR_BITS+3:4];
          g_d = vx[COLOR_BITS+2:3];
          b_d = hx[COLOR_BITS+3:4];
        end
        2'd1: begin
          r_d = bar[2] ? ONES : '0;
          g_d = bar[1] ? ONES : '0;
          b_d = bar[0] ? ONES : '0;
        end
        2'd2: begin
          r_d = (hx[4] ^ vx[4]) ? ONES : '0;
          g_d = (hx[4] ^ vx[4]) ? ONES : '0;
          b_d = (hx[4] ^ vx[4]) ? ONES : '0;
        end
        default: begin
          r_d = ONES;
          g_d = ONES;
          b_d = ONES;
        end
      endcase
    end
  end

  // Output register: everything for pixel (h,v) lands together one clk later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b1;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (enable) begin
      red         <= r_d;
      green       <= g_d;
      blue        <= b_d;
      hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      blank       <= blank_d;
      x           <= h;
      y           <= v;
      frame_start <= (h == '0) && (v == '0);
      line_start  <= (h == '0);
    end
  end

endmodule
